// File: rtl/car_park_ctrl.sv
// rtl/car_park_ctrl.sv - multi-bay car park controller: occupancy, timed barriers, capped fee quote
// Entry and exit FSMs run concurrently; bay state is shared in one sequential block.
module car_park_ctrl #(
  parameter int N_SLOTS     = 8,
  parameter int SW          = $clog2(N_SLOTS),
  parameter int TW          = 16,
  parameter int FW          = 4,
  parameter int MAX_FEE     = 5,
  parameter int GATE_CYCLES = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          sin,
  input  logic          sout,
  input  logic [SW-1:0] exit_slot,
  input  logic          pay,
  output logic          bin,
  output logic          bout,
  output logic          entry_valid,
  output logic [SW-1:0] entry_slot,
  output logic [FW-1:0] fee,
  output logic          fee_valid,
  output logic [SW:0]   free_cnt,
  output logic          full,
  output logic          err
);
  localparam int GCW = $clog2(GATE_CYCLES + 1);

  typedef enum logic {E_IDLE, E_GATE} e_state_t;
  typedef enum logic [1:0] {X_IDLE, X_QUOTE, X_WAIT, X_GATE} x_state_t;

  e_state_t           e_state_q;
  x_state_t           x_state_q;
  logic [TW-1:0]      t_q;
  logic [N_SLOTS-1:0] occ_q, occ_d;
  logic [TW-1:0]      ts_q [N_SLOTS];
  logic [GCW-1:0]     e_cnt_q, x_cnt_q;
  logic [SW-1:0]      x_slot_q;
  logic [SW:0]        free_cnt_q, free_cnt_d;
  logic               bin_q, bout_q, entry_valid_q, fee_valid_q, err_q;
  logic [SW-1:0]      entry_slot_q;
  logic [FW-1:0]      fee_q, fee_d;
  logic [SW-1:0]      alloc_idx;
  logic               do_alloc, do_release, slot_ok;
  logic [TW-1:0]      elapsed;
  logic [TW:0]        fee_sum;

  // Lowest-index free bay; only meaningful while the park is not full.
  always_comb begin
    alloc_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) alloc_idx = SW'(i);
    end
  end

  assign full       = (free_cnt_q == '0);
  assign do_alloc   = (e_state_q == E_IDLE) && sin && !full;
  assign do_release = (x_state_q == X_WAIT) && pay;
  assign slot_ok    = ({1'b0, exit_slot} < (SW+1)'(N_SLOTS)) && occ_q[exit_slot];

  // Cap is applied on the full-width sum so large durations never wrap the fee.
  assign elapsed = t_q - ts_q[x_slot_q];
  assign fee_sum = {1'b0, elapsed} + (TW+1)'(1);
  assign fee_d   = (fee_sum > (TW+1)'(MAX_FEE)) ? FW'(MAX_FEE) : FW'(fee_sum);

  always_comb begin
    occ_d = occ_q;
    if (do_alloc)   occ_d[alloc_idx] = 1'b1;
    if (do_release) occ_d[x_slot_q]  = 1'b0;
  end

  assign free_cnt_d = free_cnt_q - (SW+1)'(do_alloc) + (SW+1)'(do_release);

  always_ff @(posedge clk) begin
    if (rst) begin
      e_state_q     <= E_IDLE;
      x_state_q     <= X_IDLE;
      t_q           <= '0;
      occ_q         <= '0;
      e_cnt_q       <= '0;
      x_cnt_q       <= '0;
      x_slot_q      <= '0;
      free_cnt_q    <= (SW+1)'(N_SLOTS);
      bin_q         <= 1'b0;
      bout_q        <= 1'b0;
      entry_valid_q <= 1'b0;
      entry_slot_q  <= '0;
      fee_q         <= '0;
      fee_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (tick) t_q <= t_q + TW'(1);
      occ_q         <= occ_d;
      free_cnt_q    <= free_cnt_d;
      entry_valid_q <= 1'b0;
      err_q         <= 1'b0;

      case (e_state_q)
        E_IDLE: begin
          if (do_alloc) begin
            ts_q[alloc_idx] <= t_q;
            entry_slot_q    <= alloc_idx;
            entry_valid_q   <= 1'b1;
            bin_q           <= 1'b1;
            e_cnt_q         <= GCW'(GATE_CYCLES - 1);
            e_state_q       <= E_GATE;
          end
        end
        E_GATE: begin
          if (e_cnt_q == '0) begin
            bin_q     <= 1'b0;
            e_state_q <= E_IDLE;
          end else begin
            e_cnt_q <= e_cnt_q - GCW'(1);
          end
        end
        default: e_state_q <= E_IDLE;
      endcase

      case (x_state_q)
        X_IDLE: begin
          if (sout) begin
            if (slot_ok) begin
              x_slot_q  <= exit_slot;
              x_state_q <= X_QUOTE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        X_QUOTE: begin
          fee_q       <= fee_d;
          fee_valid_q <= 1'b1;
          x_state_q   <= X_WAIT;
        end
        X_WAIT: begin
          if (pay) begin
            fee_valid_q <= 1'b0;
            bout_q      <= 1'b1;
            x_cnt_q     <= GCW'(GATE_CYCLES - 1);
            x_state_q   <= X_GATE;
          end
        end
        X_GATE: begin
          if (x_cnt_q == '0) begin
            bout_q    <= 1'b0;
            x_state_q <= X_IDLE;
          end else begin
            x_cnt_q <= x_cnt_q - GCW'(1);
          end
        end
        default: x_state_q <= X_IDLE;
      endcase
    end
  end

  assign bin         = bin_q;
  assign bout        = bout_q;
  assign entry_valid = entry_valid_q;
  assign entry_slot  = entry_slot_q;
  assign fee         = fee_q;
  assign fee_valid   = fee_valid_q;
  assign free_cnt    = free_cnt_q;
  assign err         = err_q;
endmodule

// File: tb/tb_car_park_ctrl.sv
// tb/tb_car_park_ctrl.sv - self-checking bench for car_park_ctrl
// Table of fee vectors plus hand sequences; entry slots and fees are checked through scoreboards.
module tb_car_park_ctrl;
  localparam int G = 5;

  logic clk, rst, tick, sin, sout, pay;
  logic [2:0] exit_slot, entry_slot;
  logic bin, bout, entry_valid, fee_valid, full, err;
  logic [3:0] fee, free_cnt;

  logic tick6, sin6, sout6, pay6;
  logic [2:0] exit_slot6, entry_slot6;
  logic bin6, bout6, entry_valid6, fee_valid6, full6, err6;
  logic [3:0] fee6, free_cnt6;

  car_park_ctrl u_dut (
    .clk(clk), .rst(rst), .tick(tick), .sin(sin), .sout(sout), .exit_slot(exit_slot),
    .pay(pay), .bin(bin), .bout(bout), .entry_valid(entry_valid), .entry_slot(entry_slot),
    .fee(fee), .fee_valid(fee_valid), .free_cnt(free_cnt), .full(full), .err(err)
  );

  car_park_ctrl #(.N_SLOTS(6), .TW(8)) u_dut6 (
    .clk(clk), .rst(rst), .tick(tick6), .sin(sin6), .sout(sout6), .exit_slot(exit_slot6),
    .pay(pay6), .bin(bin6), .bout(bout6), .entry_valid(entry_valid6), .entry_slot(entry_slot6),
    .fee(fee6), .fee_valid(fee_valid6), .free_cnt(free_cnt6), .full(full6), .err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ent_q[$];
  int fee_exp_q[$];
  logic [15:0] m_t;
  bit   [7:0]  m_occ;
  logic [15:0] m_ts [8];
  logic fv_prev = 1'b0;

  typedef struct {
    int pre_ticks;
    bit co_tick;
    int hold_ticks;
    int exp_fee;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int m_free();
    int c = 0;
    for (int i = 0; i < 8; i++) if (!m_occ[i]) c++;
    return c;
  endfunction

  function automatic int m_fee(input int slot);
    logic [15:0] e;
    int f;
    e = m_t - m_ts[slot];
    f = int'(e) + 1;
    return (f > 5) ? 5 : f;
  endfunction

  task automatic cyc();
    if (tick) m_t = m_t + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic do_enter(input bit with_tick);
    int s = -1;
    for (int i = 7; i >= 0; i--) if (!m_occ[i]) s = i;
    sin  = 1'b1;
    tick = with_tick;
    if (s >= 0) begin
      m_occ[s] = 1'b1;
      m_ts[s]  = m_t;
      ent_q.push_back(s);
    end
    cyc();
    sin  = 1'b0;
    tick = 1'b0;
    if (s < 0) begin
      check("full_no_bin", 32'(bin), 0);
      check("full_no_entry", 32'(entry_valid), 0);
      return;
    end
    check("free_after_entry", 32'(free_cnt), m_free());
    for (int k = 0; k < G; k++) begin
      check("bin_open", 32'(bin), 1);
      cyc();
    end
    check("bin_closed", 32'(bin), 0);
  endtask

  task automatic do_exit(input int slot, input int exp_fee, input bit with_sin);
    bit ok;
    ok = m_occ[slot];
    sout = 1'b1;
    exit_slot = 3'(slot);
    if (ok) fee_exp_q.push_back(exp_fee);
    cyc();
    sout = 1'b0;
    check("exit_err", 32'(err), 32'(!ok));
    cyc();
    check("fee_valid_on", 32'(fee_valid), 32'(ok));
    if (!ok) return;
    pay = 1'b1;
    sin = with_sin;
    cyc();
    pay = 1'b0;
    sin = 1'b0;
    m_occ[slot] = 1'b0;
    check("fee_valid_off", 32'(fee_valid), 0);
    check("free_after_pay", 32'(free_cnt), m_free());
    if (with_sin) begin
      check("sin_with_pay_bin", 32'(bin), 0);
      check("sin_with_pay_entry", 32'(entry_valid), 0);
    end
    for (int k = 0; k < G; k++) begin
      check("bout_open", 32'(bout), 1);
      cyc();
    end
    check("bout_closed", 32'(bout), 0);
  endtask

  // Scoreboard consumers: entry slots on entry_valid, fees on the rising edge of fee_valid.
  always @(negedge clk) begin
    if (entry_valid === 1'b1) begin
      if (ent_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL entry_unexpected: actual slot %0d required no entry", entry_slot);
      end else begin
        check("entry_slot", 32'(entry_slot), ent_q.pop_front());
      end
    end
    if (fee_valid === 1'b1 && !fv_prev) begin
      if (fee_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fee_unexpected: actual fee %0d required no quote", fee);
      end else begin
        check("fee", 32'(fee), fee_exp_q.pop_front());
      end
    end
    fv_prev = (fee_valid === 1'b1);
  end

  initial begin
    vecs[0] = '{10, 1'b0, 3, 4};
    vecs[1] = '{0, 1'b0, 100, 5};
    vecs[2] = '{0, 1'b0, 0, 1};
    vecs[3] = '{0, 1'b0, 4, 5};
    vecs[4] = '{0, 1'b0, 16, 5};
    vecs[5] = '{0, 1'b1, 2, 4};

    rst = 1'b1; tick = 0; sin = 0; sout = 0; pay = 0; exit_slot = '0;
    tick6 = 0; sin6 = 0; sout6 = 0; pay6 = 0; exit_slot6 = '0;
    m_t = '0; m_occ = '0;
    for (int i = 0; i < 8; i++) m_ts[i] = '0;
    repeat (3) cyc();
    check("rst_bin", 32'(bin), 0);
    check("rst_bout", 32'(bout), 0);
    check("rst_entry_valid", 32'(entry_valid), 0);
    check("rst_entry_slot", 32'(entry_slot), 0);
    check("rst_fee", 32'(fee), 0);
    check("rst_fee_valid", 32'(fee_valid), 0);
    check("rst_free_cnt", 32'(free_cnt), 8);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    check("rst_free_cnt6", 32'(free_cnt6), 6);
    rst = 1'b0;
    cyc();

    for (int v = 0; v < 6; v++) begin
      do_tick(vecs[v].pre_ticks);
      do_enter(vecs[v].co_tick);
      do_tick(vecs[v].hold_ticks);
      do_exit(0, vecs[v].exp_fee, 1'b0);
    end

    // Reset while entry barrier is open and a quote is pending.
    do_enter(1'b0);
    sout = 1'b1; exit_slot = 3'd0; fee_exp_q.push_back(m_fee(0));
    cyc(); sout = 1'b0;
    cyc();
    check("pre_rst_fee_valid", 32'(fee_valid), 1);
    sin = 1'b1; m_occ[1] = 1'b1; ent_q.push_back(1);
    cyc(); sin = 1'b0;
    check("pre_rst_bin", 32'(bin), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_t = '0; m_occ = '0;
    check("mid_rst_bin", 32'(bin), 0);
    check("mid_rst_fee_valid", 32'(fee_valid), 0);
    check("mid_rst_free_cnt", 32'(free_cnt), 8);
    check("mid_rst_full", 32'(full), 0);
    pay = 1'b1;
    cyc(); pay = 1'b0;
    check("post_rst_pay_bout", 32'(bout), 0);
    check("post_rst_pay_free", 32'(free_cnt), 8);
    cyc();
    check("post_rst_pay_bout2", 32'(bout), 0);

    // Fill, overflow, then simultaneous release and entry on a full park.
    for (int i = 0; i < 8; i++) do_enter(1'b0);
    check("fill_free_cnt", 32'(free_cnt), 0);
    check("fill_full", 32'(full), 1);
    do_enter(1'b0);
    check("overflow_free_cnt", 32'(free_cnt), 0);
    do_tick(2);
    do_exit(3, m_fee(3), 1'b1);
    check("simul_free_cnt", 32'(free_cnt), 1);
    do_enter(1'b0);
    check("refill_full", 32'(full), 1);

    // Six-bay, 8-bit-time instance: counter wrap and rejected exits.
    tick6 = 1'b1;
    repeat (254) cyc();
    tick6 = 1'b0;
    sin6 = 1'b1;
    cyc(); sin6 = 1'b0;
    check("d6_entry_valid", 32'(entry_valid6), 1);
    check("d6_entry_slot", 32'(entry_slot6), 0);
    repeat (G) cyc();
    tick6 = 1'b1;
    repeat (3) cyc();
    tick6 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sout6 = 1'b1;
      exit_slot6 = (k == 0) ? 3'd6 : (k == 1) ? 3'd7 : 3'd1;
      cyc(); sout6 = 1'b0;
      check("d6_bad_exit_err", 32'(err6), 1);
      cyc();
      check("d6_err_one_cycle", 32'(err6), 0);
      check("d6_bad_exit_no_quote", 32'(fee_valid6), 0);
      check("d6_bad_exit_free", 32'(free_cnt6), 5);
    end
    sout6 = 1'b1; exit_slot6 = 3'd0;
    cyc(); sout6 = 1'b0;
    check("d6_exit_no_err", 32'(err6), 0);
    cyc();
    check("d6_wrap_fee_valid", 32'(fee_valid6), 1);
    check("d6_wrap_fee", 32'(fee6), 4);

    cyc();
    check("entry_sb_empty", 32'(ent_q.size()), 0);
    check("fee_sb_empty", 32'(fee_exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/car_park_ctrl.md
# car_park_ctrl

Parametrised multi-slot car park controller. It tracks occupancy of `N_SLOTS` bays, timestamps each entry against a free-running unit-time counter, and drives entry and exit barriers for a fixed number of cycles. It also quotes a capped, duration-based fee and releases a bay only after a payment handshake. It sits between the conditioned sensor/payment front end and the display/barrier drivers.

## Interface
Parameters:
- `N_SLOTS`, 8: number of bays; must be ≥2.
- `SW`, `$clog2(N_SLOTS)`: slot index width.
- `TW`, 16: time counter and timestamp width.
- `FW`, 4: fee width.
- `MAX_FEE`, 5: fee cap; must be ≤2^FW−1.
- `GATE_CYCLES`, 5: barrier open duration in clk cycles; must be ≥1.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `tick` input 1: one-cycle time-unit strobe; advances the time counter.
- `sin` input 1: one-cycle entry-request pulse.
- `sout` input 1: one-cycle exit-request pulse.
- `exit_slot` input SW: bay index presented with `sout`.
- `pay` input 1: one-cycle payment-accepted pulse.
- `bin` output 1: entry barrier open.
- `bout` output 1: exit barrier open.
- `entry_valid` output 1: one-cycle pulse; `entry_slot` is valid.
- `entry_slot` output SW: bay allocated to the entering car.
- `fee` output FW: quoted fee; valid while `fee_valid`=1.
- `fee_valid` output 1: quote pending payment.
- `free_cnt` output SW+1: number of free bays.
- `full` output 1: `free_cnt`==0.
- `err` output 1: one-cycle pulse on a rejected exit request.

## Operation
- Time counter `T` (TW bits) increments by 1 on each `tick` and wraps at 2^TW.
- Per-bay state: occupied bit `occ[i]` and timestamp `ts[i]` (TW bits).

Entry FSM, states E_IDLE and E_GATE:
- E_IDLE: if `sin`=1 and `full`=0, allocate the lowest-index bay with `occ`=0.
  - Set `occ`, store `ts` = current `T` (the value before any same-cycle `tick` increment).
  - Go to E_GATE.
- `sin` while `full`=1 or in E_GATE is dropped; no error is flagged.
- E_GATE: `bin`=1 for exactly GATE_CYCLES cycles, then return to E_IDLE.

Exit FSM, states X_IDLE, X_QUOTE, X_WAIT, X_GATE:
- X_IDLE: on `sout`=1:
  - If `exit_slot`<N_SLOTS and `occ[exit_slot]`=1, latch the slot and go to X_QUOTE.
  - Otherwise pulse `err` and stay in X_IDLE.
- `sout` in any non-idle exit state is dropped.
- X_QUOTE (1 cycle): elapsed = (T − ts[slot]) mod 2^TW; fee = min(elapsed+1, MAX_FEE). Compute the comparison in TW+1 bits, with no FW truncation before the cap. Go to X_WAIT.
- X_WAIT: `fee_valid`=1 and `fee` is held. On `pay`=1, clear `occ[slot]` and go to X_GATE. `pay` outside X_WAIT is ignored.
- X_GATE: `bout`=1 for exactly GATE_CYCLES cycles, then return to X_IDLE.

Shared rules:
- The two FSMs run independently and concurrently.
- Same-cycle allocation and release: allocation uses `occ` before the release. A full park does not admit in that cycle. `free_cnt` changes by the net amount (+1, −1 or 0).
- `free_cnt` = N_SLOTS − popcount(`occ`) and is registered. `full` is derived from the registered count.

## Timing
- Reset values:
  - Outputs: `bin`=0, `bout`=0, `entry_valid`=0, `entry_slot`=0, `fee`=0, `fee_valid`=0, `free_cnt`=N_SLOTS, `full`=0, `err`=0.
  - Internal: `T`=0, all `occ`=0; both FSMs in idle.
- Reset mid-operation: barriers close the next cycle, pending quotes are discarded, and all bays are freed.
- `sin` accepted in cycle n:
  - `entry_valid`=1 and `entry_slot` valid in cycle n+1.
  - `bin`=1 in cycles n+1 … n+GATE_CYCLES.
  - `free_cnt` decremented in n+1.
  - Next `sin` accepted from n+GATE_CYCLES+1.
- `sout` accepted in cycle n:
  - X_QUOTE in n+1; `fee_valid`=1 from n+2.
  - `err`, if raised, appears in n+1.
- `pay` in cycle m during X_WAIT:
  - `fee_valid`=0, `free_cnt` incremented and `bout`=1 in m+1.
  - `bout`=1 for m+1 … m+GATE_CYCLES.
  - X_IDLE at m+GATE_CYCLES+1.
- `tick` coincident with `sin`: the stored timestamp is the pre-increment `T`.

## Test plan
- Fill and overflow (N_SLOTS=8):
  - Stimulus: 8 spaced `sin` pulses.
  - Response: `entry_slot` 0..7 in order; `free_cnt` 8→0; `full`=1.
  - Stimulus: a 9th `sin`.
  - Response: no `bin`, no `entry_valid`.
- Fee quote:
  - Stimulus: enter at T=10; 3 ticks; `sout` on that slot.
  - Response: `fee`=4 two cycles later.
  - Stimulus: `pay`.
  - Response: `bout` high 5 cycles; `free_cnt` +1.
- Fee cap and wrap:
  - Stimulus: 100 ticks before exit.
  - Response: `fee`=5.
  - Stimulus: entry at T=65534, exit at T=1 (TW=16).
  - Response: elapsed=3, `fee`=4.
- Invalid exit:
  - Stimulus: `sout` with an unoccupied slot; separately, `sout` with `exit_slot`≥N_SLOTS (N_SLOTS=6).
  - Response: `err` pulse in each case; no `fee_valid`; `occ` unchanged.
- Simultaneous events:
  - Stimulus: park full; `pay` (releasing slot 3) and `sin` in the same cycle.
  - Response: entry rejected; `free_cnt`=1.
  - Stimulus: next `sin`.
  - Response: `entry_slot`=3.
- Reset mid-operation:
  - Stimulus: `rst` during E_GATE and X_WAIT.
  - Response: next cycle `bin`=0, `fee_valid`=0, `free_cnt`=N_SLOTS; `pay` afterwards is ignored.
